// File: rtl/clock_divider_multi_if.sv
// Bundle of control inputs and divided-clock outputs for clock_divider_multi.
// The master side drives enables and configuration; the slave side is the divider.
interface clock_divider_multi_if #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2,
   parameter int CNT_W  = 16
);
   logic [NUM_CH-1:0] ch_en;
   logic              sync_restart;
   logic              cfg_we;
   logic [CH_W-1:0]   cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic [NUM_CH-1:0] clk_div;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] div_pending;

   modport master (
      output ch_en, sync_restart, cfg_we, cfg_ch, cfg_div,
      input  clk_div, tick, div_pending
   );

   modport slave (
      input  ch_en, sync_restart, cfg_we, cfg_ch, cfg_div,
      output clk_div, tick, div_pending
   );
endinterface

// File: rtl/clock_divider_multi.sv
// Multi-channel 50%-duty clock divider with per-channel tick strobe, shadowed
// half-period registers that switch only at a half-period boundary, and a global realign.
module clock_divider_multi #(
   parameter int NUM_CH      = 4,
   parameter int CH_W        = 2,
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 5000
) (
   input  logic                  clk,
   input  logic                  reset,
   clock_divider_multi_if.slave  bus
);
   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] count;
      logic [CNT_W-1:0] active_div;
      logic [CNT_W-1:0] shadow_div;
      logic [CNT_W-1:0] div_eff;
      logic             pending;
      logic             clk_q;
      logic             tick_q;
      logic             wr;
      logic             terminal;

      // An out-of-range cfg_ch never equals any channel index, so it is ignored here.
      assign wr       = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
      assign div_eff  = (active_div == '0) ? ONE : active_div;
      assign terminal = (count == (div_eff - ONE));

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            count      <= '0;
            active_div <= DIV_RST;
            shadow_div <= DIV_RST;
            pending    <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
         end else if (bus.sync_restart || !bus.ch_en[i]) begin
            // Idle/realign: no boundary to wait for, so divisors land immediately.
            count   <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            pending <= 1'b0;
            if (wr) begin
               active_div <= bus.cfg_div;
               shadow_div <= bus.cfg_div;
            end else begin
               active_div <= shadow_div;
            end
         end else if (terminal) begin
            count   <= '0;
            clk_q   <= ~clk_q;
            tick_q  <= 1'b1;
            pending <= 1'b0;
            if (wr) begin
               active_div <= bus.cfg_div;
               shadow_div <= bus.cfg_div;
            end else begin
               active_div <= shadow_div;
            end
         end else begin
            count  <= count + ONE;
            tick_q <= 1'b0;
            if (wr) begin
               shadow_div <= bus.cfg_div;
               pending    <= 1'b1;
            end
         end
      end

      assign bus.clk_div[i]     = clk_q;
      assign bus.tick[i]        = tick_q;
      assign bus.div_pending[i] = pending;
   end
endmodule

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- Parametrised multi-channel clock divider and tick generator for the CPU board's slow logic clocks: display scan, debounce and counters.
- Each of NUM_CH channels produces a 50%-duty divided clock plus a one-cycle tick strobe. The half-period is runtime-programmable and updates glitch-free at a period boundary.
- Per-channel enable and a global phase-realign (sync_restart) are provided.

Parameters:
- NUM_CH, 4, number of independent divider channels.
- CH_W, 2, width of the channel-select field; must satisfy 2^CH_W >= NUM_CH.
- CNT_W, 16, width of the counter and divisor.
- DEFAULT_DIV, 5000, half-period in clk cycles loaded at reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ch_en  in  NUM_CH  per-channel enable (level).
- sync_restart  in  1  one-cycle pulse; realigns all channels.
- cfg_we  in  1  divisor write strobe.
- cfg_ch  in  CH_W  channel index for the write.
- cfg_div  in  CNT_W  new half-period value.
- clk_div  out  NUM_CH  divided clocks.
- tick  out  NUM_CH  one-cycle strobe at every clk_div toggle.
- div_pending  out  NUM_CH  high while a written divisor waits for a boundary.

Behaviour:
- Reset is asynchronous, active-high; clock is clk. All state is per channel.
- Per-channel registers: count[CNT_W], active_div, shadow_div, pending, clk_div, tick.
- Reset values: count=0, active_div=shadow_div=DEFAULT_DIV, pending=0, clk_div=0, tick=0, div_pending=0.
- Effective divisor D = (active_div==0) ? 1 : active_div. Divisor 0 is treated as 1.
- Enabled, normal operation:
  - If count != D-1: count<=count+1 and tick<=0.
  - If count == D-1 (terminal): count<=0, clk_div<=~clk_div, tick<=1 for one cycle.
  - clk_div period is 2*D cycles, high D and low D. For D=1, clk_div toggles every cycle and tick stays 1.
- From reset release, or on enable with count=0: clk_div first rises after D rising edges.
- Divisor write (cfg_we=1, cfg_ch<NUM_CH, channel enabled, not terminal this cycle):
  - shadow_div<=cfg_div, pending<=1.
  - At the next terminal edge: active_div<=shadow_div, pending<=0. The new value governs the following half-period; the current half-period finishes with the old D.
  - Repeated writes before the boundary: last write wins.
- Write on the channel's terminal cycle: active_div<=cfg_div and shadow_div<=cfg_div directly; pending stays 0.
- Write to a disabled channel: active_div and shadow_div take cfg_div at that edge; pending=0.
- cfg_ch >= NUM_CH: write ignored; no state change.
- Disable (ch_en[i]=0): at each edge count<=0, clk_div<=0, tick<=0. A pending shadow is applied (active<=shadow, pending<=0).
- sync_restart=1: for all channels, count<=0, clk_div<=0, tick<=0, active<=shadow, pending<=0. A cfg write in the same cycle loads active directly.
- Priority: reset > sync_restart > disable > terminal/write > count.
- Reset mid-operation: outputs clear immediately (asynchronously); any in-flight shadow is lost.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. NUM_CH=3, DEFAULT_DIV=3, ch_en=3'b111, release reset -> clk_div rises at edge 3, falls at edge 6; period 6, duty 3/3; tick high on edges 3, 6, 9...; all channels identical.
2. Write ch1 cfg_div=5 while count=1 -> div_pending[1]=1. The current half-period ends at its 3rd edge with pending cleared; subsequent half-periods are 5; ch0 and ch2 are unaffected.
3. Write cfg_div=0, then cfg_div=1, to ch0 -> clk_div[0] toggles every cycle and tick[0] stays 1 in both cases.
4. Deassert ch_en[2] mid-half-period -> next edge clk_div[2]=0, count=0. While disabled, write div=2 -> applied immediately, div_pending[2]=0. Re-enable -> clk_div[2] rises 2 edges later.
5. ch0 div=3, ch1 div=4, pulse sync_restart with a cfg write to ch2 div=6 in the same cycle -> all clk_div=0 next edge; ch0 rises at +3, ch1 at +4, ch2 at +6; pending all 0. Write cfg_ch=3 -> no change anywhere.
6. Assert reset between clock edges mid-operation -> clk_div, tick, div_pending go to 0 without a clock edge. After release, active=DEFAULT_DIV and timing matches scenario 1.
